// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between a same-cycle writeback path (A)
// and a FIFO-buffered multi-cycle unit (B). Optional macro: RF_SCOREBOARD_EN.
module rf_write_arbiter #(
  parameter int AWL    = 5,
  parameter int WL     = 32,
  parameter int QD     = 2,
  parameter int STARVE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 A_WE,
  input  logic [AWL-1:0]       A_WA,
  input  logic [WL-1:0]        A_WD,
  output logic                 A_STALL,
  input  logic                 B_VALID,
  input  logic [AWL-1:0]       B_WA,
  input  logic [WL-1:0]        B_WD,
  output logic                 B_READY,
  output logic                 RFWE,
  output logic [AWL-1:0]       RFWA,
  output logic [WL-1:0]        RFWD,
  output logic [$clog2(QD):0]  PEND,
  input  logic [AWL-1:0]       RFR1,
  input  logic [AWL-1:0]       RFR2,
  output logic                 HAZ1,
  output logic                 HAZ2
);
  localparam int PW = $clog2(QD);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE + 1);

  typedef struct packed {
    logic [AWL-1:0] wa;
    logic [WL-1:0]  wd;
  } entry_t;

  entry_t         mem [QD];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [SW-1:0]  starve;

  logic   empty, force_head, pop, push, a_grant;
  entry_t head;

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign force_head = !RST && A_WE && !empty && (starve == SW'(STARVE));
  assign pop        = !RST && !empty && (!A_WE || force_head);
  assign a_grant    = !RST && A_WE && !force_head;

  // Ready looks only at the registered count: a same-cycle pop never frees a slot.
  assign B_READY = !RST && (count != CW'(QD));
  assign push    = B_VALID && B_READY;
  assign A_STALL = force_head;
  assign PEND    = count;

  always_comb begin
    RFWE = pop || a_grant;
    RFWA = '0;
    RFWD = '0;
    if (pop) begin
      RFWA = head.wa;
      RFWD = head.wd;
    end else if (a_grant) begin
      RFWA = A_WA;
      RFWD = A_WD;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{wa: B_WA, wd: B_WD};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || empty)                 starve <= '0;
      else if (starve != SW'(STARVE))   starve <= starve + 1'b1;
    end
  end

`ifdef RF_SCOREBOARD_EN
  // Walk occupied slots from the head; stale data in freed slots is ignored.
  always_comb begin
    HAZ1 = 1'b0;
    HAZ2 = 1'b0;
    for (int k = 0; k < QD; k++) begin
      if (CW'(k) < count) begin
        if (mem[rd_ptr + PW'(k)].wa == RFR1) HAZ1 = 1'b1;
        if (mem[rd_ptr + PW'(k)].wa == RFR2) HAZ2 = 1'b1;
      end
    end
  end
`else
  logic unused_rfr;
  assign unused_rfr = ^{RFR1, RFR2};
  assign HAZ1 = 1'b0;
  assign HAZ2 = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; hazard expectations follow RF_SCOREBOARD_EN.
module tb_rf_write_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        A_WE = 1'b0;
  logic [4:0]  A_WA = '0;
  logic [31:0] A_WD = '0;
  logic        A_STALL;
  logic        B_VALID = 1'b0;
  logic [4:0]  B_WA = '0;
  logic [31:0] B_WD = '0;
  logic        B_READY;
  logic        RFWE;
  logic [4:0]  RFWA;
  logic [31:0] RFWD;
  logic [1:0]  PEND;
  logic [4:0]  RFR1 = '0;
  logic [4:0]  RFR2 = '0;
  logic        HAZ1, HAZ2;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  rf_write_arbiter #(.AWL(5), .WL(32), .QD(2), .STARVE(4)) dut (
    .CLK(CLK), .RST(RST),
    .A_WE(A_WE), .A_WA(A_WA), .A_WD(A_WD), .A_STALL(A_STALL),
    .B_VALID(B_VALID), .B_WA(B_WA), .B_WD(B_WD), .B_READY(B_READY),
    .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD), .PEND(PEND),
    .RFR1(RFR1), .RFR2(RFR2), .HAZ1(HAZ1), .HAZ2(HAZ2)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state, with A requesting to confirm gating
    A_WE = 1'b1; A_WA = 5'd1; A_WD = 32'h11;
    #2;
    check("rst_rfwe", RFWE, 0);
    check("rst_ready", B_READY, 0);
    check("rst_pend", PEND, 0);
    check("rst_stall", A_STALL, 0);
    check("rst_haz", {HAZ1, HAZ2}, 0);
    step();
    RST = 1'b0; A_WE = 1'b0;
    #1;
    check("rel_ready", B_READY, 1);
    check("rel_rfwe", RFWE, 0);

    // Single B write, A idle
    step();
    B_VALID = 1'b1; B_WA = 5'd3; B_WD = 32'hDEADBEEF;
    #1;
    check("t2_c0_rfwe", RFWE, 0);
    check("t2_c0_ready", B_READY, 1);
    step();
    B_VALID = 1'b0;
    #1;
    check("t2_c1_pend", PEND, 1);
    check("t2_c1_rfwe", RFWE, 1);
    check("t2_c1_rfwa", RFWA, 3);
    check("t2_c1_rfwd", RFWD, 32'hDEADBEEF);
    step();
    check("t2_c2_pend", PEND, 0);
    check("t2_c2_rfwe", RFWE, 0);
    check("t2_c2_rfwa", RFWA, 0);

    // Starvation bound with A held continuously
    A_WE = 1'b1; A_WA = 5'd5; A_WD = 32'd1;
    B_VALID = 1'b1; B_WA = 5'd6; B_WD = 32'h66;
    #1;
    check("t3_c0_rfwa", RFWA, 5);
    step();
    B_WA = 5'd7; B_WD = 32'h77;
    #1;
    check("t3_c1_ready", B_READY, 1);
    check("t3_c1_rfwa", RFWA, 5);
    step();
    B_VALID = 1'b0; RFR1 = 5'd7; RFR2 = 5'd8;
    #1;
    check("t3_c2_ready", B_READY, 0);
    check("t3_c2_pend", PEND, 2);
    check("t3_c2_haz1", HAZ1, SB);
    check("t3_c2_haz2", HAZ2, 0);
    for (int c = 2; c <= 11; c++) begin
      if (c == 6) begin
        RFR2 = 5'd6;
        #1;
        check("t3_c6_pend", PEND, 1);
        check("t3_c6_haz1", HAZ1, SB);
        check("t3_c6_haz2", HAZ2, 0);
      end
      check($sformatf("t3_c%0d_stall", c), A_STALL, (c == 5 || c == 10));
      check($sformatf("t3_c%0d_rfwe", c), RFWE, 1);
      check($sformatf("t3_c%0d_rfwa", c), RFWA, (c == 5) ? 6 : (c == 10) ? 7 : 5);
      check($sformatf("t3_c%0d_rfwd", c), RFWD, (c == 5) ? 32'h66 : (c == 10) ? 32'h77 : 1);
      step();
    end
    // now in cycle 12
    check("t3_end_pend", PEND, 0);
    check("t3_end_haz1", HAZ1, 0);
    check("t3_end_stall", A_STALL, 0);

    // Simultaneous A and B with empty queue
    A_WA = 5'd2; A_WD = 32'h20;
    B_VALID = 1'b1; B_WA = 5'd9; B_WD = 32'h90;
    #1;
    check("t4_c0_rfwa", RFWA, 2);
    check("t4_c0_rfwd", RFWD, 32'h20);
    check("t4_c0_stall", A_STALL, 0);
    step();
    A_WE = 1'b0; B_VALID = 1'b0;
    #1;
    check("t4_c1_rfwe", RFWE, 1);
    check("t4_c1_rfwa", RFWA, 9);
    check("t4_c1_rfwd", RFWD, 32'h90);
    step();
    check("t4_c2_rfwe", RFWE, 0);
    check("t4_c2_pend", PEND, 0);

    // Full queue: no push even when popping the same cycle
    A_WE = 1'b1; A_WA = 5'd4; A_WD = 32'h44;
    B_VALID = 1'b1; B_WA = 5'd10; B_WD = 32'hA0;
    step();
    B_WA = 5'd11; B_WD = 32'hB0;
    step();
    A_WE = 1'b0; B_WA = 5'd12; B_WD = 32'hC0;
    #1;
    check("t5_full_pend", PEND, 2);
    check("t5_full_ready", B_READY, 0);
    check("t5_full_rfwa", RFWA, 10);
    step();
    A_WE = 1'b1;
    #1;
    check("t5_pend1", PEND, 1);
    check("t5_ready1", B_READY, 1);
    check("t5_agrant", RFWA, 4);
    step();
    A_WE = 1'b0; B_VALID = 1'b0;
    #1;
    check("t5_pend2", PEND, 2);
    check("t5_drain1", RFWA, 11);
    step();
    check("t5_drain2", RFWA, 12);
    check("t5_drain2_wd", RFWD, 32'hC0);
    step();
    check("t5_empty", PEND, 0);
    check("t5_empty_rfwe", RFWE, 0);

    // Mid-run reset discards a queued entry
    A_WE = 1'b1; A_WA = 5'd1; B_VALID = 1'b1; B_WA = 5'd13; B_WD = 32'hD0;
    step();
    B_VALID = 1'b0; RFR1 = 5'd13;
    #1;
    check("t1_pre_pend", PEND, 1);
    check("t1_pre_haz1", HAZ1, SB);
    #1 RST = 1'b1;
    #1;
    check("t1_mid_rfwe", RFWE, 0);
    check("t1_mid_ready", B_READY, 0);
    check("t1_mid_pend", PEND, 0);
    check("t1_mid_haz1", HAZ1, 0);
    step();
    RST = 1'b0; A_WE = 1'b0;
    #1;
    check("t1_rel_ready", B_READY, 1);
    check("t1_rel_rfwe", RFWE, 0);
    step();
    check("t1_rel2_rfwe", RFWE, 0);
    check("t1_rel2_pend", PEND, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
